vram_bus_master: RTL and testbench
==================================

// Module: vram_bus_master
// PURPOSE
//  Initiator side of the main-RAM slave bus (15b word addr, 32b data, 4b byte-select, write strobe).
//  Accepts byte/halfword/word requests from a host port (CPU register file or DMA) through a small
//  request queue. Converts them to word accesses with lane steering, and returns right-aligned read data.
//  Honours a per-cycle grant from the VRAM arbiter so that video fetch can steal slots.
// PARAMETERS
//  VRAM_SIZE_BYTES  131072  RAM size; 65536 and 131072 supported; byte addresses wrap modulo this
//  QUEUE_DEPTH      2       request queue entries; power of two, >=2
// PORTS
//  clk            in   1   clock; all logic on rising edge
//  rst_n          in   1   synchronous reset, active low
//  req_valid      in   1   host request valid
//  req_ready      out  1   queue not full; transfer when req_valid & req_ready
//  req_write      in   1   1=write, 0=read
//  req_size       in   2   0=byte, 1=halfword, 2=word, 3=illegal
//  req_addr       in   17  byte address
//  req_wrdata     in   32  write data, right-aligned (byte in [7:0], halfword in [15:0])
//  req_err        out  1   1-cycle pulse: request rejected (misaligned or size 3)
//  rsp_valid      out  1   1-cycle pulse: read data valid; no backpressure
//  rsp_rddata     out  32  read data, right-aligned, upper unused bits zero
//  bus_gnt        in   1   arbiter grant for the current cycle
//  bus_addr       out  15  word address to RAM
//  bus_wrdata     out  32  lane-steered write data
//  bus_wrbytesel  out  4   byte enables, bit n = byte lane n
//  bus_write      out  1   write strobe
//  bus_rddata     in   32  RAM read word, valid the cycle after the address is presented
// BEHAVIOUR
//  Reset: queue empty; req_ready=0 during reset, 1 first cycle after; req_err, rsp_valid, bus_write,
//   bus_wrbytesel, bus_addr, bus_wrdata, rsp_rddata = 0; in-flight read tags discarded (no rsp pulse).
//  Accept: on req_valid&req_ready, illegal requests are not queued; req_err=1 next cycle.
//   Illegal: size 3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0.
//  req_ready = !full; no same-cycle bypass when full, even if head pops that cycle.
//  Issue (combinational from queue head): if !empty & bus_gnt, then drive bus and pop head.
//   bus_addr = addr[16:2] & ((VRAM_SIZE_BYTES/4)-1); lane = addr[1:0].
//   bytesel: byte 4'b0001<<lane, halfword 4'b0011<<lane, word 4'b1111.
//   write: bus_write=1, bus_wrdata = wrdata << (8*lane).
//   read: bus_write=0, bytesel=0; push {lane,size} into 1-deep return stage.
//  If empty or !bus_gnt: bus_write=0, bus_wrbytesel=0, bus_addr holds last value, head stays.
//  Return: cycle after a read issue, capture (bus_rddata >> 8*lane) masked to size into rsp_rddata.
//   Assert rsp_valid in the following cycle.
//  Latency: accept in cycle 0 -> issue in cycle 1 (if granted) -> rsp_valid in cycle 3.
//   Write commits at the end of cycle 1.
//  Throughput: one access per granted cycle; back-to-back reads are pipelined.
//  Ordering: strictly in order. A read after a write to the same word sees the new data.
//  Simultaneous accept and pop: count is unchanged; pointers advance independently; pointers wrap
//   modulo QUEUE_DEPTH.
//  Reset mid-read: a return stage that is valid at reset is dropped.
// STRUCTURE
//  vram_bus_pkg: SIZE_BYTE/HALF/WORD/ILLEGAL encodings, VRAM_ADDR_W=17, BUS_ADDR_W=15, DATA_W=32,
//   function lane_mask(size,lane).
//  Sub-module sync_fifo (WIDTH=1+2+17+32, DEPTH=QUEUE_DEPTH) for the request queue. Issue, steering
//   and the return stage stay in this module.
// TESTING
//  Write byte 0xA5 @0x00003, gnt=1 -> bus_addr=0, bytesel=4'b1000, wrdata=0xA5000000, bus_write 1 cycle.
//  Word write 0x11223344 @0x10, then halfword read @0x12 -> rsp_rddata=0x00001122,
//   rsp_valid 3 cycles after read accept.
//  Halfword @0x1, word @0x6, size 3 -> req_err pulse each time, no bus activity, queue unchanged.
//  Fill queue with gnt=0 -> req_ready=0 after QUEUE_DEPTH accepts. Raise gnt -> in-order issue,
//   one per cycle.
//  4 back-to-back byte reads @0x20..0x23 with gnt toggling 1,0,1,1,0,1 -> 4 rsp in order, data correct.
//  VRAM_SIZE_BYTES=65536: write @0x10004 -> bus_addr=0x0001. rst_n low cycle after a read issue ->
//   no rsp_valid; all outputs 0.

Source files
------------

// File: rtl/vram_bus_pkg.sv
// vram_bus_pkg
//   Shared widths, request-size encodings, queue/return-stage record types and
//   lane helpers for the VRAM bus master and its request queue.
package vram_bus_pkg;

    localparam int unsigned VRAM_ADDR_W = 17;  // host byte address
    localparam int unsigned BUS_ADDR_W  = 15;  // RAM word address
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    // One queued host request.
    typedef struct packed {
        logic                   write;
        size_e                  size;
        logic [VRAM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      wrdata;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    // What the return stage needs to right-align a read word.
    typedef struct packed {
        logic [1:0] lane;
        size_e      size;
    } ret_t;

    // Byte enables for an access of the given size starting at byte lane 'lane'.
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << lane;
            SIZE_HALF: mask = 4'b0011 << lane;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Keeps only the bits a right-aligned result of this size may use.
    function automatic logic [DATA_W-1:0] size_mask(input size_e size);
        logic [DATA_W-1:0] mask;
        mask = '0;
        case (size)
            SIZE_BYTE: mask = 32'h0000_00ff;
            SIZE_HALF: mask = 32'h0000_ffff;
            SIZE_WORD: mask = 32'hffff_ffff;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

    // Size 3, or an access not naturally aligned to its own size.
    function automatic logic req_illegal(input size_e size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE:    bad = 1'b0;
            SIZE_HALF:    bad = lane[0];
            SIZE_WORD:    bad = |lane;
            SIZE_ILLEGAL: bad = 1'b1;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO used as the host request queue. DEPTH must be a power of
//   two so the read/write pointers wrap naturally. Push while full and pop while
//   empty are ignored. Push and pop in the same cycle leave the count unchanged.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   synchronous reset, active low (empties the queue)
//   push   in   write wdata at the tail
//   wdata  in   WIDTH-bit entry
//   pop    in   drop the head entry
//   rdata  out  head entry (meaningless while empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rdata = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they exist.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vram_bus_master.sv
// vram_bus_master
//   Initiator on the main-RAM slave bus. Host byte/halfword/word requests are
//   checked for alignment, queued, then issued one per granted cycle as word
//   accesses with lane steering. Read words come back one cycle after the
//   address and are right-aligned into rsp_rddata, pulsed with rsp_valid.
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   req_valid/req_ready  host handshake (ready = queue not full)
//   req_write/size/addr/wrdata  host request fields, write data right-aligned
//   req_err              1-cycle pulse: accepted request was illegal and dropped
//   rsp_valid/rsp_rddata 1-cycle read response, right-aligned, zero-extended
//   bus_gnt              arbiter grant for this cycle
//   bus_addr/wrdata/wrbytesel/write  RAM access, driven combinationally from queue head
//   bus_rddata           RAM read word, valid the cycle after the address
module vram_bus_master
    import vram_bus_pkg::*;
#(
    parameter int unsigned VRAM_SIZE_BYTES = 131072,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic [VRAM_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]      req_wrdata,
    output logic                   req_err,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rddata,
    input  logic                   bus_gnt,
    output logic [BUS_ADDR_W-1:0]  bus_addr,
    output logic [DATA_W-1:0]      bus_wrdata,
    output logic [3:0]             bus_wrbytesel,
    output logic                   bus_write,
    input  logic [DATA_W-1:0]      bus_rddata
);

    // Word-address wrap for the configured RAM size.
    localparam logic [BUS_ADDR_W-1:0] WORD_MASK = BUS_ADDR_W'((VRAM_SIZE_BYTES / 4) - 1);

    req_t                  in_req;
    req_t                  head;
    logic [REQ_W-1:0]      head_raw;
    logic [1:0]            head_lane;
    logic                  q_full, q_empty;
    logic                  accept, in_illegal, push, issue;

    logic [BUS_ADDR_W-1:0] addr_q;
    ret_t                  ret_q, ret_d;
    logic                  ret_valid_q, ret_valid_d;
    logic [DATA_W-1:0]     rsp_rddata_q, rsp_rddata_d;
    logic                  rsp_valid_q;
    logic                  req_err_q, req_err_d;

    // ---------------------------------------------------------------- accept
    always_comb begin
        in_req.write  = req_write;
        in_req.size   = size_e'(req_size);
        in_req.addr   = req_addr;
        in_req.wrdata = req_wrdata;
        in_illegal    = req_illegal(in_req.size, req_addr[1:0]);
        // No bypass: a pop in the same cycle does not make room for this request.
        req_ready     = rst_n & ~q_full;
        accept        = req_valid & req_ready;
        push          = accept & ~in_illegal;
        req_err_d     = accept & in_illegal;
    end

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_req),
        .pop   (issue),
        .rdata (head_raw),
        .full  (q_full),
        .empty (q_empty)
    );

    // ----------------------------------------------------------------- issue
    always_comb begin
        head          = req_t'(head_raw);
        head_lane     = head.addr[1:0];
        // Gating with rst_n keeps every bus output quiet while reset is held.
        issue         = rst_n & ~q_empty & bus_gnt;
        bus_addr      = rst_n ? addr_q : '0;
        bus_write     = 1'b0;
        bus_wrbytesel = 4'b0000;
        bus_wrdata    = '0;
        ret_valid_d   = 1'b0;
        ret_d         = ret_q;
        if (issue) begin
            bus_addr = head.addr[VRAM_ADDR_W-1:2] & WORD_MASK;
            if (head.write) begin
                bus_write     = 1'b1;
                bus_wrbytesel = lane_mask(head.size, head_lane);
                bus_wrdata    = head.wrdata << {head_lane, 3'b000};
            end else begin
                ret_valid_d = 1'b1;
                ret_d.lane  = head_lane;
                ret_d.size  = head.size;
            end
        end
    end

    // ---------------------------------------------------------------- return
    always_comb begin
        rsp_rddata_d = rsp_rddata_q;
        if (ret_valid_q) begin
            rsp_rddata_d = (bus_rddata >> {ret_q.lane, 3'b000}) & size_mask(ret_q.size);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q       <= '0;
            ret_valid_q  <= 1'b0;
            ret_q        <= '{lane: 2'd0, size: SIZE_BYTE};
            rsp_valid_q  <= 1'b0;
            rsp_rddata_q <= '0;
            req_err_q    <= 1'b0;
        end else begin
            addr_q       <= bus_addr;
            ret_valid_q  <= ret_valid_d;
            ret_q        <= ret_d;
            rsp_valid_q  <= ret_valid_q;
            rsp_rddata_q <= rsp_rddata_d;
            req_err_q    <= req_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rddata = rsp_rddata_q;
    assign req_err    = req_err_q;

endmodule

// File: tb/tb_vram_bus_master.sv
// tb_vram_bus_master
//   Drives two masters (128 KiB and 64 KiB) with shared host/grant inputs. A
//   word RAM answers the 128 KiB instance's bus. Read results are predicted by a
//   byte-addressed memory model; bus-level expectations come from directed cases.
module tb_vram_bus_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_write, bus_gnt;
    logic [1:0]  req_size;
    logic [16:0] req_addr;
    logic [31:0] req_wrdata, bus_rddata;

    logic        req_ready, req_err, rsp_valid, bus_write;
    logic [31:0] rsp_rddata, bus_wrdata;
    logic [14:0] bus_addr;
    logic [3:0]  bus_wrbytesel;

    logic        s_req_ready, s_req_err, s_rsp_valid, s_bus_write;
    logic [31:0] s_rsp_rddata, s_bus_wrdata;
    logic [14:0] s_bus_addr;
    logic [3:0]  s_bus_wrbytesel;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] ram     [32768];
    logic [7:0]  ref_mem [131072];

    vram_bus_master #(.VRAM_SIZE_BYTES(131072), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
        .req_wrdata(req_wrdata), .req_err(req_err), .rsp_valid(rsp_valid),
        .rsp_rddata(rsp_rddata), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
        .bus_wrdata(bus_wrdata), .bus_wrbytesel(bus_wrbytesel), .bus_write(bus_write),
        .bus_rddata(bus_rddata)
    );

    vram_bus_master #(.VRAM_SIZE_BYTES(65536), .QUEUE_DEPTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
        .req_wrdata(req_wrdata), .req_err(s_req_err), .rsp_valid(s_rsp_valid),
        .rsp_rddata(s_rsp_rddata), .bus_gnt(bus_gnt), .bus_addr(s_bus_addr),
        .bus_wrdata(s_bus_wrdata), .bus_wrbytesel(s_bus_wrbytesel), .bus_write(s_bus_write),
        .bus_rddata(bus_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read word registered one cycle after the address, byte-enabled writes.
    initial begin : ram_model
        logic [31:0] w;
        for (int i = 0; i < 32768; i++) ram[i] = $urandom;
        bus_rddata = '0;
        forever begin
            @(posedge clk);
            bus_rddata <= ram[bus_addr];
            if (bus_write) begin
                w = ram[bus_addr];
                for (int b = 0; b < 4; b++)
                    if (bus_wrbytesel[b]) w[8*b +: 8] = bus_wrdata[8*b +: 8];
                ram[bus_addr] = w;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [1:0] s,
                           input logic [16:0] a, input logic [31:0] d);
        req_valid = v; req_write = w; req_size = s; req_addr = a; req_wrdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_gnt = 1'b0;
        set_req(1'b0, 1'b0, 2'd0, '0, '0);
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if ({req_ready, req_err, rsp_valid, bus_write, bus_wrbytesel, bus_addr, bus_wrdata,
             rsp_rddata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b err=%b rv=%b bw=%b sel=%h a=%h wd=%h rd=%h want all 0",
                     req_ready, req_err, rsp_valid, bus_write, bus_wrbytesel, bus_addr,
                     bus_wrdata, rsp_rddata);
        end
        tick(); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    task automatic test_byte_write();
        tick(); bus_gnt = 1'b1;
        set_req(1'b1, 1'b1, 2'd0, 17'h00003, 32'h0000_00a5);
        tick(); req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_write, bus_wrbytesel, bus_addr, bus_wrdata} !==
            {1'b1, 4'b1000, 15'h0, 32'ha500_0000}) begin
            n_fail++;
            $display("FAIL byte_write_issue: got bw=%b sel=%b a=%h wd=%h want 1 1000 0 a5000000",
                     bus_write, bus_wrbytesel, bus_addr, bus_wrdata);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({bus_write, bus_wrbytesel, bus_addr} !== {1'b0, 4'b0000, 15'h0}) begin
            n_fail++;
            $display("FAIL byte_write_single_cycle: got bw=%b sel=%b a=%h want 0 0000 0",
                     bus_write, bus_wrbytesel, bus_addr);
        end
    endtask

    task automatic test_read_after_write();
        tick(); set_req(1'b1, 1'b1, 2'd2, 17'h00010, 32'h1122_3344);
        tick(); set_req(1'b1, 1'b0, 2'd1, 17'h00012, 32'h0);
        tick(); req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_write, bus_wrbytesel, bus_addr, rsp_valid} !== {1'b0, 4'b0000, 15'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL raw_read_issue: got bw=%b sel=%b a=%h rv=%b want 0 0000 4 0",
                     bus_write, bus_wrbytesel, bus_addr, rsp_valid);
        end
        tick(); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL raw_early_rsp: got %b want 0", rsp_valid);
        end
        tick(); @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_rddata} !== {1'b1, 32'h0000_1122}) begin
            n_fail++;
            $display("FAIL raw_rsp: got rv=%b rd=%h want 1 00001122", rsp_valid, rsp_rddata);
        end
        tick(); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL raw_rsp_pulse: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_illegal();
        logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
        logic [16:0] ad [3] = '{17'h1, 17'h6, 17'h8};
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) set_req(1'b1, 1'b0, sz[k], ad[k], 32'h0);
            else req_valid = 1'b0;
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (req_err !== 1'b1) begin
                    n_fail++; $display("FAIL illegal_err_%0d: got %b want 1", k - 1, req_err);
                end
            end
            n_checks++;
            if ({req_ready, bus_write, bus_wrbytesel, bus_addr, rsp_valid} !==
                {1'b1, 1'b0, 4'b0000, 15'h4, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_no_bus_%0d: got rdy=%b bw=%b sel=%b a=%h rv=%b want 1 0 0 4 0",
                         k, req_ready, bus_write, bus_wrbytesel, bus_addr, rsp_valid);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick(); @(negedge clk);
            n_checks++;
            if ({req_err, rsp_valid, bus_addr} !== {1'b0, 1'b0, 15'h4}) begin
                n_fail++;
                $display("FAIL illegal_quiet_%0d: got err=%b rv=%b a=%h want 0 0 4",
                         k, req_err, rsp_valid, bus_addr);
            end
        end
    endtask

    task automatic test_fill();
        logic [16:0] fa [3] = '{17'h40, 17'h44, 17'h48};
        logic [31:0] fd [3] = '{32'ha0a0_0001, 32'ha0a0_0002, 32'ha0a0_0003};
        logic        exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            tick();
            bus_gnt = (k == 4);
            set_req(1'b1, 1'b1, 2'd2, fa[(k < 2) ? k : 2], fd[(k < 2) ? k : 2]);
            @(negedge clk);
            n_checks++;
            if (req_ready !== exp_rdy[k]) begin
                n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", k, req_ready, exp_rdy[k]);
            end
            if (k < 4) begin
                n_checks++;
                if (bus_write !== 1'b0) begin
                    n_fail++; $display("FAIL fill_no_gnt_%0d: got bw=%b want 0", k, bus_write);
                end
            end
        end
        // Grant raised in the last iteration: entries 0,1,2 issue on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                tick();
                if (k == 2) req_valid = 1'b0;
                @(negedge clk);
            end
            n_checks++;
            if ({bus_write, bus_wrbytesel, bus_addr, bus_wrdata} !==
                {1'b1, 4'b1111, 15'(fa[k] >> 2), fd[k]}) begin
                n_fail++;
                $display("FAIL fill_issue_%0d: got bw=%b sel=%b a=%h wd=%h want 1 1111 %h %h",
                         k, bus_write, bus_wrbytesel, bus_addr, bus_wrdata, fa[k] >> 2, fd[k]);
            end
        end
        tick(); @(negedge clk);
        n_checks++;
        if ({bus_write, bus_addr, req_ready} !== {1'b0, 15'h12, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_drained: got bw=%b a=%h rdy=%b want 0 12 1",
                     bus_write, bus_addr, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_b [4] = '{32'hef, 32'hbe, 32'had, 32'hde};
        logic        pat [6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          sent = 0;
        int          got  = 0;
        logic        prev_acc = 1'b0;
        tick(); bus_gnt = 1'b1; set_req(1'b1, 1'b1, 2'd2, 17'h20, 32'hdead_beef);
        tick(); req_valid = 1'b0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            tick();
            if (prev_acc) sent++;
            set_req(sent < 4, 1'b0, 2'd0, 17'h20 + 17'(sent), 32'h0);
            bus_gnt = (c >= 1 && c <= 6) ? pat[c - 1] : 1'b1;
            @(negedge clk);
            prev_acc = req_valid && req_ready;
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (got >= 4 || rsp_rddata !== exp_b[got]) begin
                    n_fail++;
                    $display("FAIL b2b_rsp_%0d: got %h want %h", got, rsp_rddata,
                             (got < 4) ? exp_b[got] : 32'hx);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d responses want 4", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic        err_exp = 1'b0;
        logic        acc, bad;
        logic [31:0] val;
        logic [16:0] a;
        int          n;
        for (int i = 0; i < 131072; i++) ref_mem[i] = ram[i >> 2][8 * (i % 4) +: 8];
        for (int c = 0; c < 640; c++) begin
            tick();
            if (c < 600) begin
                a = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'h100 + 17'($urandom_range(0, 31));
                set_req($urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom_range(0, 3)), a, $urandom);
                bus_gnt = $urandom_range(0, 3) != 0;
            end else begin
                req_valid = 1'b0; bus_gnt = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (req_err !== err_exp) begin
                n_fail++; $display("FAIL rand_err_c%0d: got %b want %b", c, req_err, err_exp);
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_rsp_c%0d: got %h want none", c, rsp_rddata);
                end else begin
                    val = exp_q.pop_front();
                    if (rsp_rddata !== val) begin
                        n_fail++; $display("FAIL rand_rsp_c%0d: got %h want %h", c, rsp_rddata, val);
                    end
                end
            end
            acc = req_valid && req_ready;
            bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                  (req_size == 2'd2 && req_addr[1:0] != 2'b00);
            err_exp = acc && bad;
            if (acc && !bad) begin
                n = 1 << req_size;
                if (req_write) begin
                    for (int b = 0; b < n; b++) ref_mem[int'(req_addr) + b] = req_wrdata[8*b +: 8];
                end else begin
                    val = '0;
                    for (int b = 0; b < n; b++) val[8*b +: 8] = ref_mem[int'(req_addr) + b];
                    exp_q.push_back(val);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        tick(); bus_gnt = 1'b1; set_req(1'b1, 1'b1, 2'd2, 17'h10004, 32'h5555_aaaa);
        tick(); req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_bus_write, s_bus_wrbytesel, s_bus_addr} !== {1'b1, 4'b1111, 15'h0001}) begin
            n_fail++;
            $display("FAIL wrap_64k: got bw=%b sel=%b a=%h want 1 1111 0001",
                     s_bus_write, s_bus_wrbytesel, s_bus_addr);
        end
        n_checks++;
        if ({bus_write, bus_addr} !== {1'b1, 15'h4001}) begin
            n_fail++; $display("FAIL wrap_128k: got bw=%b a=%h want 1 4001", bus_write, bus_addr);
        end
    endtask

    task automatic test_reset_mid_read();
        tick(); bus_gnt = 1'b1; set_req(1'b1, 1'b0, 2'd2, 17'h00010, 32'h0);
        tick(); req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_write, bus_addr} !== {1'b0, 15'h4}) begin
            n_fail++; $display("FAIL midrst_issue: got bw=%b a=%h want 0 4", bus_write, bus_addr);
        end
        tick(); rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({req_ready, req_err, rsp_valid, bus_write, bus_wrbytesel, bus_addr, bus_wrdata,
             rsp_rddata, s_req_ready, s_rsp_valid, s_bus_write, s_bus_addr} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rdy=%b err=%b rv=%b bw=%b sel=%h a=%h wd=%h rd=%h want all 0",
                     req_ready, req_err, rsp_valid, bus_write, bus_wrbytesel, bus_addr,
                     bus_wrdata, rsp_rddata);
        end
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL midrst_no_rsp_%0d: got %b want 0", k, rsp_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_read_after_write();
        test_illegal();
        test_fill();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
